fifo_burst_reader_m: RTL

//  Drain stage placed directly after a single-clock FWFT FIFO with read data count.

---
 rtl/fifo_burst_reader_m_if.sv | 31 +++
 rtl/fifo_burst_reader_m.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader_m_if.sv
// Handshake bundle between the FWFT FIFO read side, the burst reader and the downstream burst sink.
// The reader connects through the slave modport; the master modport drives it from the FIFO/sink side.
interface fifo_burst_reader_m_if #(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DATA_COUNT_W   = 6,
    parameter int  LEN_W          = 5
);
    DATA_ITEM_TYPE            head;
    logic                     empty;
    logic [DATA_COUNT_W-1:0]  data_count;
    logic                     rd_rst_busy;
    logic                     pop;
    DATA_ITEM_TYPE            out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_first;
    logic                     out_last;
    logic [LEN_W-1:0]         out_len;
    logic [31:0]              burst_cnt;
    logic [31:0]              flush_cnt;

    modport slave (
        input  head, empty, data_count, rd_rst_busy, out_ready,
        output pop, out_data, out_valid, out_first, out_last, out_len, burst_cnt, flush_cnt
    );

    modport master (
        output head, empty, data_count, rd_rst_busy, out_ready,
        input  pop, out_data, out_valid, out_first, out_last, out_len, burst_cnt, flush_cnt
    );
endinterface

// File: rtl/fifo_burst_reader_m.sv
// Drains a FWFT FIFO into framed valid/ready bursts: full BURST_LEN bursts, or a tail flush after TIMEOUT.
// Optional statistics counters are built when FIFO_BURST_READER_STAT_EN is defined.
module fifo_burst_reader_m #(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter int  BURST_LEN      = 16,
    parameter int  TIMEOUT        = 64,
    localparam int DATA_COUNT_W   = $clog2(DEPTH + 1),
    localparam int LEN_W          = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    fifo_burst_reader_m_if.slave bus,
    output logic             dbg_state_o,
    output logic [LEN_W-1:0] dbg_beat_o
);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_COUNT_W-1:0] BL_COUNT_C = DATA_COUNT_W'(BURST_LEN);
    localparam logic [LEN_W-1:0]        BL_LEN_C   = LEN_W'(BURST_LEN);
    localparam logic [TIMER_W-1:0]      TIMEOUT_C  = TIMER_W'(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [LEN_W-1:0]     len_q, len_d;

    DATA_ITEM_TYPE        head_w;
    logic                 valid_w;
    logic                 last_w;
    logic                 pop_w;
    logic                 full_start_w;
    logic                 to_start_w;

    // Handshake: a beat transfers on a cycle where out_valid && out_ready; that same cycle pops the FIFO.
    assign head_w       = bus.head;
    assign valid_w      = (state_q == BURST) && !bus.empty && !bus.rd_rst_busy;
    assign last_w       = (state_q == BURST) && (beat_q == len_q - LEN_W'(1));
    assign pop_w        = valid_w && bus.out_ready;
    assign full_start_w = (bus.data_count >= BL_COUNT_C);
    assign to_start_w   = (timer_q == TIMEOUT_C) && (bus.data_count != '0);

    assign bus.pop       = pop_w;
    assign bus.out_valid = valid_w;
    assign bus.out_data  = (state_q == BURST) ? head_w : '0;
    assign bus.out_first = (state_q == BURST) && (beat_q == '0);
    assign bus.out_last  = last_w;
    assign bus.out_len   = len_q;
    assign dbg_state_o   = state_q;
    assign dbg_beat_o    = beat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            beat_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        beat_d  = beat_q;
        len_d   = len_q;
        if (bus.rd_rst_busy) begin
            // Read side in reset: abandon any burst without a last beat.
            state_d = IDLE;
            timer_d = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full_start_w) begin
                        state_d = BURST;
                        len_d   = BL_LEN_C;
                        beat_d  = '0;
                        timer_d = '0;
                    end else if (to_start_w) begin
                        state_d = BURST;
                        len_d   = LEN_W'(bus.data_count);
                        beat_d  = '0;
                        timer_d = '0;
                    end else if (!bus.empty && (bus.data_count < BL_COUNT_C)) begin
                        timer_d = (timer_q == TIMEOUT_C) ? timer_q : timer_q + TIMER_W'(1);
                    end else begin
                        timer_d = '0;
                    end
                end
                BURST: begin
                    if (pop_w) begin
                        if (last_w) begin
                            state_d = IDLE;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + LEN_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STAT_EN
    logic        flush_start_w;
    logic [31:0] burst_cnt_q;
    logic [31:0] flush_cnt_q;

    // A flush is a timeout start that the full-length condition did not pre-empt.
    assign flush_start_w = (state_q == IDLE) && !bus.rd_rst_busy && !full_start_w && to_start_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop_w && last_w) burst_cnt_q <= burst_cnt_q + 32'd1;
            if (flush_start_w)   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.burst_cnt = burst_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.burst_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(bus.pop && bus.empty));
    a_no_idle_valid: assert property (@(posedge clk) disable iff (rst) !(bus.out_valid && state_q == IDLE));
    a_len_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == BURST) |-> (len_q >= LEN_W'(1) && len_q <= BL_LEN_C));
endmodule
